ifu_fetch: RTL and testbench

Instruction fetch initiator for the npc core: owns the PC, issues one word-fetch request at a time to the instruction memory port and delivers the returned instruction with its PC to decode over a valid/ready handshake. Sits between the PC-redirect logic (branch/jump/exception) and the instruction memory. At most one memory request is outstanding. Responses belonging to a redirected-away PC are discarded.

---
 rtl/npc_ifu_pkg.sv | 13 +
 rtl/ifu_fetch.sv | 142 ++++++++++++++
 tb/tb_ifu_fetch.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/npc_ifu_pkg.sv
// npc_ifu_pkg: shared definitions for the npc instruction fetch unit.
//   - 2-bit fetch FSM state encoding (REQ / WAIT / HOLD / HALT)
//   - IFU_RESET_PC: default PC fetched first after reset
package npc_ifu_pkg;

  localparam logic [1:0] REQ  = 2'd0;  // request pending toward memory
  localparam logic [1:0] WAIT = 2'd1;  // request accepted, awaiting response
  localparam logic [1:0] HOLD = 2'd2;  // instruction registered, presenting to decode
  localparam logic [1:0] HALT = 2'd3;  // parked after a misaligned-PC fault

  localparam logic [31:0] IFU_RESET_PC = 32'h8000_0000;

endpackage

// File: rtl/ifu_fetch.sv
// ifu_fetch: instruction fetch initiator. Owns the PC, issues one word fetch at
// a time, and presents the returned word with its PC to decode.
//
// Optional feature macro: IFU_ALIGN_CHK_EN
//   defined   -> a misaligned PC raises inst_fault instead of fetching, then
//                the unit parks in HALT until redirect or reset.
//   undefined -> no alignment check, inst_fault tied 0, no HALT state.
//
// Ports:
//   clk, rst_n        clock (rising edge), synchronous active-low reset
//   mem_req_*         fetch request: valid/ready handshake, byte address = pc
//   mem_rsp_*         fetch response: always accepted, one per accepted request
//   inst_*            instruction to decode: valid/ready, pc, word, fault marker
//   redirect_*        new PC from branch/jump/exception; kills in-flight fetch
module ifu_fetch
  import npc_ifu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = IFU_RESET_PC
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_req_addr,
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rsp_data,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_pc,
  output logic [31:0] inst,
  output logic        inst_fault,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc
);

  logic [1:0]  state;
  logic [31:0] pc;
  logic [31:0] inst_r;
  logic        drop;       // outstanding response belongs to a redirected-away PC
  logic        misaligned;
  logic        req_fire;
  logic        inst_fire;

`ifdef IFU_ALIGN_CHK_EN
  logic fault_r;
  assign misaligned = |pc[1:0];
  assign inst_fault = fault_r;
`else
  assign misaligned = 1'b0;
  assign inst_fault = 1'b0;
`endif

  // Valids are masked by redirect in the same cycle so that no request with a
  // stale PC is accepted and decode never consumes an instruction being killed.
  // rst_n also masks them so nothing is offered while reset is held.
  assign mem_req_valid = rst_n & (state == REQ) & ~misaligned & ~redirect_valid;
  assign inst_valid    = rst_n & (state == HOLD) & ~redirect_valid;

  assign mem_req_addr = pc;
  assign inst_pc      = pc;
  assign inst         = inst_r;

  assign req_fire  = mem_req_valid & mem_req_ready;
  assign inst_fire = inst_valid & inst_ready;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: inst_r is a plain register (not a memory array), so it is reset
      // to give decode a defined inst value from the first cycle.
      state  <= REQ;
      pc     <= RESET_PC;
      inst_r <= '0;
      drop   <= 1'b0;
`ifdef IFU_ALIGN_CHK_EN
      fault_r <= 1'b0;
`endif
    end else if (redirect_valid) begin
      pc <= redirect_pc;
`ifdef IFU_ALIGN_CHK_EN
      fault_r <= 1'b0;
`endif
      if ((state == WAIT) && !mem_rsp_valid) begin
        // The old request is still in flight: wait for its response and bin it.
        drop  <= 1'b1;
        state <= WAIT;
      end else begin
        // Any same-cycle response is discarded along with the old PC.
        drop  <= 1'b0;
        state <= REQ;
      end
    end else begin
      case (state)
        REQ: begin
`ifdef IFU_ALIGN_CHK_EN
          if (misaligned) begin
            inst_r  <= '0;
            fault_r <= 1'b1;
            state   <= HOLD;
          end else
`endif
          if (req_fire) begin
            state <= WAIT;
          end
        end
        WAIT: begin
          if (mem_rsp_valid) begin
            if (drop) begin
              drop  <= 1'b0;
              state <= REQ;
            end else begin
              inst_r <= mem_rsp_data;
              state  <= HOLD;
            end
          end
        end
        HOLD: begin
          if (inst_fire) begin
`ifdef IFU_ALIGN_CHK_EN
            if (fault_r) begin
              state <= HALT;
            end else
`endif
            begin
              pc    <= pc + 32'd4;  // wraps silently at 2^32
              state <= REQ;
            end
          end
        end
        default: begin
`ifdef IFU_ALIGN_CHK_EN
          state <= HALT;  // only redirect or reset leave HALT
`else
          state <= REQ;
`endif
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ifu_fetch.sv
// tb_ifu_fetch: randomized self-checking bench for ifu_fetch.
// A transaction-level reference model tracks the PC the fetcher should be on,
// whether a fetch is outstanding (and stale), and whether an instruction is
// being held for decode; every cycle the DUT outputs are compared against it.
// The memory model answers each accepted request after a random latency with a
// word derived from its address, so a stale word reaching decode is visible.
module tb_ifu_fetch;
  import npc_ifu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mem_req_valid;
  logic        mem_req_ready = 1'b0;
  logic [31:0] mem_req_addr;
  logic        mem_rsp_valid = 1'b0;
  logic [31:0] mem_rsp_data = '0;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] inst_pc;
  logic [31:0] inst;
  logic        inst_fault;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;

  ifu_fetch dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_req_addr  (mem_req_addr),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rsp_data  (mem_rsp_data),
    .inst_valid    (inst_valid),
    .inst_ready    (inst_ready),
    .inst_pc       (inst_pc),
    .inst          (inst),
    .inst_fault    (inst_fault),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Memory contents: distinct per word near each other; 0x8000_0000 -> 0x13.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a << 5) ^ 32'h0000_0013;
  endfunction

  // Stimulus knobs
  int rdy_pct = 100, ir_pct = 100, redir_pct = 0, lat_min = 1, lat_max = 1;
  localparam int SHOT_NONE = 0, SHOT_NOW = 1, SHOT_WAIT = 2, SHOT_RSP = 3, SHOT_HOLD = 4;
  int          shot = SHOT_NONE;
  logic [31:0] shot_pc = '0;

  // Memory model
  logic        mem_pend = 1'b0;
  int          mem_wait = 0;
  logic [31:0] mem_addr = '0;

  // Reference model
  logic [31:0] m_pc = IFU_RESET_PC;
  logic        m_out = 1'b0, m_stale = 1'b0, m_hold = 1'b0, m_fault = 1'b0, m_halt = 1'b0;
  int          cyc = 0;
  int          first_iv = 0;

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    redirect_valid = 1'b0;
    mem_rsp_valid = 1'b0;
    mem_req_ready = 1'b0;
    inst_ready = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check("rst_req_valid", mem_req_valid, 1'b0);
      check("rst_inst_valid", inst_valid, 1'b0);
      check("rst_inst_pc", inst_pc, IFU_RESET_PC);
      check("rst_inst", inst, 32'h0);
      check("rst_inst_fault", inst_fault, 1'b0);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    mem_pend = 1'b0;
    m_pc = IFU_RESET_PC;
    m_out = 1'b0; m_stale = 1'b0; m_hold = 1'b0; m_fault = 1'b0; m_halt = 1'b0;
    cyc = 1;
    first_iv = 0;
  endtask

  task automatic one_cycle();
    logic        rsp, redir, ir, fire, idle, al, e_req, e_iv;
    logic        o, h, f;
    logic [31:0] rpc;
    @(negedge clk);
    rsp = mem_pend && (mem_wait == 1);
    mem_rsp_valid = rsp;
    mem_rsp_data  = rsp ? mem_word(mem_addr) : $urandom;
    mem_req_ready = ($urandom_range(99) < rdy_pct);
    ir    = ($urandom_range(99) < ir_pct);
    redir = ($urandom_range(99) < redir_pct);
    if ($urandom_range(7) == 0) rpc = 32'hFFFF_FFF8 | {29'h0, 1'($urandom), 2'b00};
    else rpc = {16'h8000, 14'($urandom), 2'b00};
    fire = 1'b0;
    case (shot)
      SHOT_NOW:  fire = 1'b1;
      SHOT_WAIT: fire = m_out && !rsp;
      SHOT_RSP:  fire = m_out && rsp;
      SHOT_HOLD: fire = m_hold;
      default:   fire = 1'b0;
    endcase
    if (fire) begin
      redir = 1'b1;
      ir    = 1'b1;  // a decode-ready in the redirect cycle must not be honoured
      rpc   = shot_pc;
      shot  = SHOT_NONE;
    end
    redirect_valid = redir;
    redirect_pc    = rpc;
    inst_ready     = ir;
    #1;
    // Expected outputs from the model
    idle = !m_out && !m_hold && !m_halt;
`ifdef IFU_ALIGN_CHK_EN
    al = (m_pc[1:0] == 2'b00);
`else
    al = 1'b1;
`endif
    e_req = idle && al && !redir;
    e_iv  = m_hold && !redir;
    check("req_valid", mem_req_valid, e_req);
    if (e_req) check("req_addr", mem_req_addr, m_pc);
    check("inst_valid", inst_valid, e_iv);
    check("inst_pc", inst_pc, m_pc);
    if (e_iv) begin
      check("inst", inst, m_fault ? 32'h0 : mem_word(m_pc));
      check("inst_fault", inst_fault, m_fault);
    end
    if (inst_valid && first_iv == 0) first_iv = cyc;
    // Memory model follows what the DUT actually does
    if (rsp) mem_pend = 1'b0;
    else if (mem_pend) mem_wait--;
    if (mem_req_valid && mem_req_ready) begin
      mem_pend = 1'b1;
      mem_wait = $urandom_range(lat_max, lat_min);
      mem_addr = mem_req_addr;
    end
    // Reference model update
    o = m_out; h = m_hold; f = m_fault;
    if (redir) begin
      m_pc = rpc; m_hold = 1'b0; m_fault = 1'b0; m_halt = 1'b0;
      if (o) begin
        if (rsp) begin m_out = 1'b0; m_stale = 1'b0; end
        else m_stale = 1'b1;
      end
    end else begin
      if (idle) begin
        if (!al) begin m_hold = 1'b1; m_fault = 1'b1; end
        else if (mem_req_ready) m_out = 1'b1;
      end
      if (o && rsp) begin
        m_out = 1'b0;
        if (m_stale) m_stale = 1'b0;
        else begin m_hold = 1'b1; m_fault = 1'b0; end
      end
      if (h && ir) begin
        m_hold = 1'b0;
        if (f) m_halt = 1'b1;
        else m_pc = m_pc + 32'd4;
      end
    end
    cyc++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) one_cycle();
  endtask

  task automatic run_shot(input int kind, input logic [31:0] pc, input int n, input string tag);
    shot = kind;
    shot_pc = pc;
    run(n);
    check(tag, shot, SHOT_NONE);
    shot = SHOT_NONE;
  endtask

  initial begin
    do_reset();

    // Zero-wait memory out of reset: req at cycle 1, inst_valid at cycle 3.
    rdy_pct = 100; lat_min = 1; lat_max = 1; ir_pct = 100; redir_pct = 0;
    run(12);
    check("first_inst_valid_cycle", first_iv, 3);

    // Memory stalls acceptance for 5 cycles, then 3-cycle latency; decode slow.
    rdy_pct = 0;
    run(5);
    rdy_pct = 100; lat_min = 3; lat_max = 3; ir_pct = 0;
    run(8);
    ir_pct = 100;
    run(4);

    // Redirect while a fetch is in flight: stale response must be dropped.
    run_shot(SHOT_WAIT, 32'h8000_0100, 12, "redirect_in_wait_fired");
    // Redirect coincident with the response, then with a decode handshake.
    run_shot(SHOT_RSP, 32'h8000_0400, 12, "redirect_with_rsp_fired");
    run_shot(SHOT_HOLD, 32'h8000_0800, 12, "redirect_in_hold_fired");

    // Decode stalls while holding: outputs stable, no memory request.
    lat_min = 1; lat_max = 1; ir_pct = 0;
    run(8);
    ir_pct = 100;
    run(4);

    // PC wrap at the top of the address space.
    run_shot(SHOT_NOW, 32'hFFFF_FFF8, 12, "redirect_wrap_fired");

`ifdef IFU_ALIGN_CHK_EN
    // Misaligned redirect -> fault presented, then HALT; redirect resumes.
    run_shot(SHOT_NOW, 32'h8000_0102, 8, "redirect_misaligned_fired");
    run_shot(SHOT_NOW, 32'h8000_0200, 10, "redirect_resume_fired");
`endif

    // Randomized traffic with varying memory, decode and redirect behaviour.
    for (int blk = 0; blk < 30; blk++) begin
      rdy_pct   = $urandom_range(100, 30);
      ir_pct    = $urandom_range(100, 30);
      redir_pct = $urandom_range(15, 0);
      lat_min   = 1;
      lat_max   = $urandom_range(4, 1);
      run(100);
    end
    redir_pct = 0;

    // Reset with a fetch possibly outstanding; fetching restarts at RESET_PC.
    lat_min = 3; lat_max = 3;
    run(2);
    do_reset();
    lat_min = 1; lat_max = 1; rdy_pct = 100; ir_pct = 100;
    run(12);
    check("first_inst_valid_after_rereset", first_iv, 3);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
